// File: rtl/return_addr_stack_if.sv
// Branch-predictor <-> return-address-stack signal bundle: pipeline stall/flush,
// return/call class indications, call link address, and the predicted return target.
interface return_addr_stack_if #(
    parameter int XLEN = 32
);
    logic            StallF;
    logic            StallD;
    logic            StallE;
    logic            StallM;
    logic            FlushD;
    logic            FlushE;
    logic            FlushM;
    logic            BPReturnF;
    logic            ReturnD;
    logic            BPReturnWrongD;
    logic            CallE;
    logic [XLEN-1:0] PCLinkE;
    logic [XLEN-1:0] RASPCF;
    logic            RASValidF;

    modport master (
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
        output BPReturnF, ReturnD, BPReturnWrongD, CallE, PCLinkE,
        input  RASPCF, RASValidF
    );

    modport slave (
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
        input  BPReturnF, ReturnD, BPReturnWrongD, CallE, PCLinkE,
        output RASPCF, RASValidF
    );
endinterface

// File: rtl/return_addr_stack.sv
// Speculative return-address stack with pointer repair for squashed/mispredicted pops.
// Optional occupancy counter driving RASValidF is enabled by defining RAS_OCCUPANCY_EN.
module return_addr_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input logic               clk,
    input logic               reset,
    return_addr_stack_if.slave bp
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 3;
    localparam logic signed [DW-1:0] ONE = DW'(1);

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [XLEN-1:0]        ras_q [DEPTH];
    logic [XLEN-1:0]        ras_d [DEPTH];
    logic                   eff_pop_d_q, eff_pop_d_d;
    logic                   eff_pop_e_q, eff_pop_e_d;
    logic                   pop_f, undo_d, miss_d, kill_d, kill_e, push_e;
    logic signed [DW-1:0]   delta;

    // FlushE kills the D instruction outright, so it takes priority over the wrong-class repair.
    assign pop_f  = bp.BPReturnF & ~bp.StallF & ~bp.FlushD;
    assign undo_d = bp.BPReturnWrongD & eff_pop_d_q & ~bp.StallD & ~bp.FlushE;
    assign miss_d = bp.BPReturnWrongD & ~eff_pop_d_q & bp.ReturnD & ~bp.StallD & ~bp.FlushE;
    assign kill_d = bp.FlushE & eff_pop_d_q;
    assign kill_e = bp.FlushM & eff_pop_e_q;
    assign push_e = bp.CallE & ~bp.StallM & ~bp.FlushM;

    always_comb begin
        delta = '0;
        if (pop_f)  delta = delta - ONE;
        if (undo_d) delta = delta + ONE;
        if (miss_d) delta = delta - ONE;
        if (kill_d) delta = delta + ONE;
        if (kill_e) delta = delta + ONE;
        if (push_e) delta = delta + ONE;
    end

    // Push lands on the post-update pointer, i.e. Ptr + other deltas + 1.
    always_comb begin
        ptr_d = PW'(DW'(ptr_q) + $unsigned(delta));
        ras_d = ras_q;
        if (push_e) ras_d[ptr_d] = bp.PCLinkE;
    end

    always_comb begin
        eff_pop_d_d = eff_pop_d_q;
        eff_pop_e_d = eff_pop_e_q;
        if (bp.FlushD)      eff_pop_d_d = 1'b0;
        else if (!bp.StallD) eff_pop_d_d = pop_f;
        if (bp.FlushE)      eff_pop_e_d = 1'b0;
        else if (!bp.StallE) eff_pop_e_d = (eff_pop_d_q ^ undo_d) | miss_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            eff_pop_d_q <= 1'b0;
            eff_pop_e_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ras_q[i] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            eff_pop_d_q <= eff_pop_d_d;
            eff_pop_e_q <= eff_pop_e_d;
            ras_q       <= ras_d;
        end
    end

    assign bp.RASPCF = ras_q[ptr_q];

`ifdef RAS_OCCUPANCY_EN
    localparam logic signed [DW-1:0] DEPTH_S = DW'(DEPTH);

    logic [PW:0] count_q, count_d;

    function automatic logic [PW:0] sat_count(input logic signed [DW-1:0] sum);
        if (sum < 0)            return '0;
        else if (sum > DEPTH_S) return (PW + 1)'(DEPTH);
        else                    return sum[PW:0];
    endfunction

    always_comb begin
        count_d = sat_count($signed({2'b00, count_q}) + delta);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign bp.RASValidF = (count_q != '0);
`else
    assign bp.RASValidF = 1'b1;
`endif

endmodule
